adsb_rx_core: RTL and testbench

//  Next-generation ADS-B receive core. Takes log-magnitude samples, finds Mode S preambles,
//  PPM-demodulates the data bits and delivers assembled frame bytes, with per-byte confidence.

---
 rtl/adsb_rx_if.sv | 37 +++
 rtl/adsb_rx_core.sv | 179 +++++++++++++++++
 tb/tb_adsb_rx_core.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adsb_rx_if.sv
// Sample-side inputs and frame-side outputs of the ADS-B receive core.
// The core attaches to the slave modport; whatever feeds samples and takes bytes uses master.
interface adsb_rx_if #(
    parameter int width = 10,
    parameter int SPS   = 4
);
    localparam int AW = width + $clog2(SPS);

    logic             ena;
    logic             det_ena;
    logic [1:0]       mode;
    logic [width-1:0] mtl;
    logic [AW-1:0]    conf_thresh;
    logic [width-1:0] logmag;
    logic             trigger;
    logic             data_start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_conf;
    logic             frame_done;
    logic             frame_abort;
    logic             frame_long;
    logic [6:0]       lowconf_cnt;
    logic             busy;

    modport master (
        output ena, det_ena, mode, mtl, conf_thresh, logmag,
        input  trigger, data_start, byte_valid, byte_data, byte_conf,
               frame_done, frame_abort, frame_long, lowconf_cnt, busy
    );

    modport slave (
        input  ena, det_ena, mode, mtl, conf_thresh, logmag,
        output trigger, data_start, byte_valid, byte_data, byte_conf,
               frame_done, frame_abort, frame_long, lowconf_cnt, busy
    );
endinterface

// File: rtl/adsb_rx_core.sv
// ADS-B receive core: Mode S preamble search, PPM bit demodulation and byte assembly.
// state    | meaning
// IDLE     | waiting for a sliced sample with det_ena=1
// PREAMBLE | collecting 16 chips of slice hits, verdict on the last sample
// DATA     | demodulating bits until 56/112 bits or det_ena drops
module adsb_rx_core #(
    parameter int width = 10,
    parameter int SPS   = 4
) (
    input  logic      clock,
    input  logic      reset,
    adsb_rx_if.slave  rx
);
    localparam int AW = width + $clog2(SPS);
    localparam int SW = $clog2(SPS);
    localparam int PW = SW + 4;
    localparam int DW = SW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PREAMBLE = 2'd1, DATA = 2'd2} state_t;
    state_t state, state_nxt;

    logic          s;
    logic [PW-1:0] pre_left;
    logic [SW:0]   chip_cnt;
    logic [SW:0]   chip_sum;
    logic          chip_hit;
    logic [14:0]   hits;
    logic          pre_pass;
    logic [DW-1:0] bit_left;
    logic [AW-1:0] sum_a, sum_b, sum_b_fin, diff;
    logic          bit_val, bit_conf, long_now, long_sel, last_bit;
    logic [6:0]    bit_idx;
    logic [6:0]    byte_sr;
    logic          byte_ok, byte_ok_fin;
    logic          go, trig_ev, pre_end, bit_end, byte_end;
    logic          busy_c, trig_c, start_c, valid_c, done_c, abort_c;
    logic          trigger_r, data_start_r, byte_valid_r, byte_conf_r;
    logic          frame_done_r, frame_abort_r, frame_long_r;
    logic [7:0]    byte_data_r;
    logic [6:0]    lowconf_r;

    assign s        = rx.logmag >= rx.mtl;
    assign go       = rx.ena & rx.det_ena;
    assign chip_sum = chip_cnt + {{SW{1'b0}}, s};
    assign chip_hit = chip_sum > (SW+1)'(SPS/2);
    // chips 0..9 sit in hits[14:5], chip 0 oldest
    assign pre_pass = hits[14:5] == 10'b1010000101;

    assign sum_b_fin   = sum_b + AW'(rx.logmag);
    assign bit_val     = sum_a > sum_b_fin;
    assign diff        = bit_val ? (sum_a - sum_b_fin) : (sum_b_fin - sum_a);
    assign bit_conf    = diff >= rx.conf_thresh;
    assign long_now    = (rx.mode == 2'b10) ? 1'b1 : (rx.mode == 2'b01) ? 1'b0 : bit_val;
    assign long_sel    = (bit_idx == 7'd0) ? long_now : frame_long_r;
    assign last_bit    = bit_idx == (long_sel ? 7'd111 : 7'd55);
    assign byte_ok_fin = ((bit_idx[2:0] == 3'd0) ? 1'b1 : byte_ok) & bit_conf;

    assign trig_ev  = (state == IDLE) & go & s;
    assign pre_end  = (state == PREAMBLE) & go & (pre_left == '0);
    assign bit_end  = (state == DATA) & go & (bit_left == '0);
    assign byte_end = bit_end & (bit_idx[2:0] == 3'd7);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (trig_ev) state_nxt = PREAMBLE;
            PREAMBLE: if (!rx.det_ena) state_nxt = IDLE;
                      else if (pre_end) state_nxt = pre_pass ? DATA : IDLE;
            DATA:     if (!rx.det_ena || (bit_end && last_bit)) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c  = state != IDLE;
        trig_c  = trig_ev;
        start_c = pre_end & pre_pass;
        valid_c = byte_end;
        done_c  = bit_end & last_bit;
        abort_c = (state == DATA) & ~rx.det_ena;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_left     <= '0;
            chip_cnt     <= '0;
            hits         <= '0;
            bit_left     <= '0;
            sum_a        <= '0;
            sum_b        <= '0;
            bit_idx      <= '0;
            byte_sr      <= '0;
            byte_ok      <= 1'b0;
            frame_long_r <= 1'b0;
            lowconf_r    <= '0;
        end else begin
            case (state)
                IDLE: if (trig_ev) begin
                    // the triggering sample is chip 0, sample 0
                    pre_left <= PW'(16*SPS-2);
                    chip_cnt <= (SW+1)'(1);
                    hits     <= '0;
                end
                PREAMBLE: if (go) begin
                    pre_left <= pre_left - PW'(1);
                    if (pre_left[SW-1:0] == '0) begin
                        hits     <= {hits[13:0], chip_hit};
                        chip_cnt <= '0;
                    end else begin
                        chip_cnt <= chip_sum;
                    end
                    if (pre_end && pre_pass) begin
                        bit_left     <= DW'(2*SPS-1);
                        sum_a        <= '0;
                        sum_b        <= '0;
                        bit_idx      <= '0;
                        frame_long_r <= 1'b0;
                        lowconf_r    <= '0;
                    end
                end
                DATA: if (go) begin
                    if (bit_left == '0) begin
                        bit_left <= DW'(2*SPS-1);
                        sum_a    <= '0;
                        sum_b    <= '0;
                        bit_idx  <= bit_idx + 7'd1;
                        byte_sr  <= {byte_sr[5:0], bit_val};
                        byte_ok  <= byte_ok_fin;
                        if (bit_idx == 7'd0) frame_long_r <= long_now;
                        if (!bit_conf && lowconf_r != 7'd112) lowconf_r <= lowconf_r + 7'd1;
                    end else begin
                        bit_left <= bit_left - DW'(1);
                        if (bit_left[SW]) sum_a <= sum_a + AW'(rx.logmag);
                        else              sum_b <= sum_b + AW'(rx.logmag);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trigger_r     <= 1'b0;
            data_start_r  <= 1'b0;
            byte_valid_r  <= 1'b0;
            byte_data_r   <= '0;
            byte_conf_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_abort_r <= 1'b0;
        end else begin
            trigger_r     <= trig_c;
            data_start_r  <= start_c;
            byte_valid_r  <= valid_c;
            frame_done_r  <= done_c;
            frame_abort_r <= abort_c;
            if (valid_c) begin
                byte_data_r <= {byte_sr, bit_val};
                byte_conf_r <= byte_ok_fin;
            end
        end
    end

    assign rx.trigger     = trigger_r;
    assign rx.data_start  = data_start_r;
    assign rx.byte_valid  = byte_valid_r;
    assign rx.byte_data   = byte_data_r;
    assign rx.byte_conf   = byte_conf_r;
    assign rx.frame_done  = frame_done_r;
    assign rx.frame_abort = frame_abort_r;
    assign rx.frame_long  = frame_long_r;
    assign rx.lowconf_cnt = lowconf_r;
    assign rx.busy        = busy_c;
endmodule

// File: tb/tb_adsb_rx_core.sv
// Randomized scoreboard bench for adsb_rx_core: frames are synthesized as sample streams,
// expected bytes come from chip sums of those samples, a monitor pops and compares.
module tb_adsb_rx_core;
    localparam int width = 10;
    localparam int SPS   = 4;
    localparam int AW    = width + $clog2(SPS);
    localparam int HI    = 800;
    localparam int LO    = 100;
    localparam int AMB   = 500;
    localparam logic [15:0] PRE_OK  = 16'b1010000101000000;
    localparam logic [15:0] PRE_BAD = 16'b1010000001000000;

    typedef struct {
        bit         is_abort;
        logic [7:0] data;
        bit         conf;
        bit         done;
        bit         long_f;
        int         lowconf;
        int         rel;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    adsb_rx_if #(.width(width), .SPS(SPS)) rx ();
    adsb_rx_core #(.width(width), .SPS(SPS)) dut (.clock(clock), .reset(reset), .rx(rx));

    always #5 clock = ~clock;

    exp_t sbq[$];
    exp_t e;
    int checks = 0, errors = 0;
    int n_samp = 0, trig_n = 0, ds_n = 0;
    int got_trig = 0, got_ds = 0, exp_trig = 0, exp_ds = 0;
    int gap = 0;
    bit rand_gap = 1'b0;
    logic [111:0] rf;
    logic [1:0]   rm;
    int           ra;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int outs();
        return int'({rx.trigger, rx.data_start, rx.byte_valid, rx.byte_data, rx.byte_conf,
                     rx.frame_done, rx.frame_abort, rx.frame_long, rx.lowconf_cnt, rx.busy});
    endfunction

    function automatic int lvl(input int base);
        return base + int'($urandom_range(0, 80)) - 40;
    endfunction

    // monitor: decoupled from stimulus, checks every output event against the queue
    always @(negedge clock) begin
        if (!reset) begin
            if (rx.trigger) begin
                got_trig++;
                trig_n = n_samp;
            end
            if (rx.data_start) begin
                got_ds++;
                chk("data_start_latency", n_samp - trig_n, 63);
                ds_n = n_samp;
            end
            if (rx.frame_done) chk("frame_done_with_byte", rx.byte_valid, 1);
            if (rx.byte_valid || rx.frame_abort) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_event", int'(rx.byte_valid) + int'(rx.frame_abort), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("event_is_abort", rx.frame_abort, e.is_abort);
                    if (!e.is_abort) begin
                        chk("byte_data", rx.byte_data, e.data);
                        chk("byte_conf", rx.byte_conf, e.conf);
                        chk("frame_done", rx.frame_done, e.done);
                        chk("frame_long", rx.frame_long, e.long_f);
                        chk("byte_timing", n_samp - ds_n, e.rel);
                        if (e.done) chk("lowconf_cnt", rx.lowconf_cnt, e.lowconf);
                    end
                end
            end
        end
    end

    task automatic put(input int v);
        int g;
        g = rand_gap ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
            rx.ena = 1'b0;
            @(posedge clock);
            #1;
        end
        rx.ena    = 1'b1;
        rx.logmag = width'(v);
        @(posedge clock);
        n_samp++;
        #1;
        rx.ena = 1'b0;
    endtask

    task automatic floor_samples(input int n);
        repeat (n) put(lvl(LO));
    endtask

    task automatic send_preamble(input logic [15:0] pat, input bit pass);
        for (int c = 15; c >= 0; c--) begin
            for (int k = 0; k < SPS; k++) begin
                put(pat[c] ? lvl(HI) : lvl(LO));
                if (c == 0 && k == SPS-2) chk("busy_before_preamble_end", rx.busy, 1);
                if (c == 0 && k == SPS-1) chk("busy_after_preamble", rx.busy, int'(pass));
            end
        end
    endtask

    // kind: 0 = complete frame, 1 = det_ena abort inside bit stop_bit, 2 = reset inside bit stop_bit
    task automatic send_frame(input logic [111:0] frame, input logic [1:0] md,
                              input int amb_bit, input int stop_bit, input int kind);
        int   smp[$];
        int   sa, sb, v, nbits, nlow, stop;
        bit   bits[112];
        bit   confs[112];
        bit   lng;
        exp_t x;
        rx.mode = md;
        for (int b = 0; b < 112; b++) begin
            sa = 0;
            sb = 0;
            for (int k = 0; k < 2*SPS; k++) begin
                if (b == amb_bit)                    v = AMB;
                else if ((k < SPS) == frame[111-b])  v = lvl(HI);
                else                                 v = lvl(LO);
                smp.push_back(v);
                if (k < SPS) sa += v;
                else         sb += v;
            end
            bits[b]  = sa > sb;
            confs[b] = ((sa > sb) ? sa - sb : sb - sa) >= int'(rx.conf_thresh);
        end
        lng   = (md == 2'b10) ? 1'b1 : (md == 2'b01) ? 1'b0 : bits[0];
        nbits = lng ? 112 : 56;
        stop  = (stop_bit > nbits) ? nbits : stop_bit;
        nlow  = 0;
        for (int j = 0; j < stop/8; j++) begin
            x.is_abort = 1'b0;
            x.data     = 8'h00;
            x.conf     = 1'b1;
            for (int i = 0; i < 8; i++) begin
                x.data = {x.data[6:0], bits[8*j+i]};
                x.conf = x.conf & confs[8*j+i];
                if (!confs[8*j+i]) nlow++;
            end
            x.done    = (8*j+8 == nbits);
            x.long_f  = lng;
            x.lowconf = (nlow > 112) ? 112 : nlow;
            x.rel     = (8*j+8)*2*SPS;
            sbq.push_back(x);
        end
        if (kind == 1) begin
            x          = '{default: 0};
            x.is_abort = 1'b1;
            sbq.push_back(x);
        end
        exp_trig++;
        exp_ds++;
        send_preamble(PRE_OK, 1'b1);
        for (int i = 0; i < stop*2*SPS; i++) put(smp[i]);
        if (kind == 1) begin
            for (int i = 0; i < 3; i++) put(smp[stop*2*SPS + i]);
            rx.det_ena = 1'b0;
            rx.ena     = 1'b1;
            rx.logmag  = width'(lvl(HI));
            @(posedge clock);
            #1;
            chk("abort_pulse", rx.frame_abort, 1);
            chk("abort_busy", rx.busy, 0);
            rx.det_ena = 1'b1;
            rx.ena     = 1'b0;
        end else if (kind == 2) begin
            for (int i = 0; i < 2; i++) put(smp[stop*2*SPS + i]);
            reset = 1'b1;
            #1;
            chk("reset_mid_data_outputs", outs(), 0);
            @(posedge clock);
            #1;
            reset = 1'b0;
        end
        floor_samples(4);
    endtask

    initial begin
        rx.ena         = 1'b0;
        rx.det_ena     = 1'b1;
        rx.mode        = 2'b00;
        rx.mtl         = width'(400);
        rx.conf_thresh = AW'(200);
        rx.logmag      = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", outs(), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        floor_samples(5);

        // DF=11 short frame, then DF=17 long frame
        send_frame({56'h5D4840D6202CC3, 56'h0}, 2'b00, -1, 112, 0);
        send_frame(112'h8D4840D6202CC371C32CE0576098, 2'b00, -1, 112, 0);

        // preamble missing chip 7, then a good frame 10 samples later
        exp_trig++;
        send_preamble(PRE_BAD, 1'b0);
        floor_samples(10);
        send_frame({56'h5D4840D6202CC3, 56'h0}, 2'b00, -1, 112, 0);

        // ambiguous bit 20: tie decides 0, byte 2 not confident
        send_frame({56'h5D4840D6202CC3, 56'h0}, 2'b00, 20, 112, 0);

        // det_ena drop inside byte 4 of a long frame
        send_frame(112'h8D4840D6202CC371C32CE0576098, 2'b00, -1, 36, 1);

        // forced 112-bit with DF=11; forced 56-bit with DF=17
        send_frame({56'h5D4840D6202CC3, 32'hA5C3_1E77, 24'h9B2D40}, 2'b10, -1, 112, 0);
        send_frame(112'h8D4840D6202CC371C32CE0576098, 2'b01, -1, 112, 0);

        // ena every third clock
        gap = 2;
        send_frame({56'h5D4840D6202CC3, 56'h0}, 2'b00, -1, 112, 0);
        gap = 0;

        // reset mid-DATA, then a clean frame
        send_frame(112'h8D4840D6202CC371C32CE0576098, 2'b00, -1, 20, 2);
        send_frame({56'h5D4840D6202CC3, 56'h0}, 2'b00, -1, 112, 0);

        // det_ena low in IDLE blocks triggering
        rx.det_ena = 1'b0;
        put(lvl(HI));
        put(lvl(HI));
        chk("idle_det_ena_blocks", rx.busy, 0);
        rx.det_ena = 1'b1;
        floor_samples(3);

        // randomized frames, modes, thresholds, ena gaps and ambiguous bits
        for (int t = 0; t < 8; t++) begin
            rf             = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
            rm             = 2'($urandom_range(0, 3));
            rx.conf_thresh = AW'($urandom_range(0, 300));
            rand_gap       = 1'($urandom_range(0, 1));
            ra             = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 111)) : -1;
            send_frame(rf, rm, ra, 112, 0);
        end
        rand_gap = 1'b0;

        floor_samples(5);
        chk("queue_empty", sbq.size(), 0);
        chk("trigger_count", got_trig, exp_trig);
        chk("data_start_count", got_ds, exp_ds);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
